// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI responder serving a 3-byte instruction/data register protocol
// Oversamples sclk/csb/sdi in the clk domain and serves single-byte reads and writes.
module spi_reg_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          ADDR_BITS   = 4,
  parameter logic [7:0]  CHIP_ID     = 8'h87
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        csb,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic        reg_wr_en,
  output logic [12:0] reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        frame_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {IDLE, INSTR, RD_DATA, WR_DATA, IGNORE, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, sdi_sync;
  logic sclk_d, csb_d;
  logic sclk_s, csb_s, sdi_s;
  logic sclk_rise, sclk_fall, csb_rise, csb_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      csb_sync  <= '1;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      csb_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_d    <= sclk_s;
      csb_d     <= csb_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  // sclk activity only counts while the chip is selected
  assign sclk_rise = sclk_s & ~sclk_d & ~csb_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~csb_s;
  assign csb_rise  = csb_s & ~csb_d;
  assign csb_fall  = ~csb_s & csb_d;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic        overrun, w_bad, wr_pend;
  logic [14:0] instr;
  logic [12:0] addr_q;
  logic [7:0]  shift_out, data_sh;
  logic [7:0]  mem [DEPTH];

  logic [15:0] instr_next;
  logic [12:0] dec_addr;
  logic [7:0]  rd_byte, wr_byte;
  logic        wr_ok, abort_err;

  always_comb begin
    instr_next = {instr, sdi_s};
    dec_addr   = instr_next[12:0];
    wr_byte    = {data_sh[6:0], sdi_s};
    rd_byte    = 8'h00;
    if (dec_addr == 13'd1)
      rd_byte = CHIP_ID;
    else if ((dec_addr >> ADDR_BITS) == 13'd0)
      rd_byte = mem[dec_addr[ADDR_BITS-1:0]];
    wr_ok     = ((addr_q >> ADDR_BITS) == 13'd0) && (addr_q != 13'd1);
    abort_err = (bit_cnt != 5'd0) && (bit_cnt < 5'd24);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      overrun     <= 1'b0;
      w_bad       <= 1'b0;
      wr_pend     <= 1'b0;
      instr       <= '0;
      addr_q      <= '0;
      shift_out   <= '0;
      data_sh     <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      reg_wr_en <= 1'b0;
      frame_err <= 1'b0;
      if (wr_pend) begin
        reg_wr_en   <= 1'b1;
        reg_wr_addr <= addr_q;
        reg_wr_data <= data_sh;
        wr_pend     <= 1'b0;
      end
      // csb release takes priority over any sclk edge seen in the same clk
      if (csb_rise) begin
        state     <= IDLE;
        sdo       <= 1'b0;
        sdo_oe    <= 1'b0;
        frame_err <= abort_err || overrun || w_bad;
        bit_cnt   <= '0;
        overrun   <= 1'b0;
        w_bad     <= 1'b0;
      end else if (state == IDLE) begin
        if (csb_fall) begin
          state   <= INSTR;
          bit_cnt <= '0;
          overrun <= 1'b0;
          w_bad   <= 1'b0;
        end
      end else begin
        if (sclk_rise) begin
          if (bit_cnt == 5'd24) overrun <= 1'b1;
          else                  bit_cnt <= bit_cnt + 5'd1;
        end
        case (state)
          INSTR: if (sclk_rise) begin
            instr <= instr_next[14:0];
            if (bit_cnt == 5'd15) begin
              addr_q <= dec_addr;
              if (instr_next[14:13] != 2'b00) begin
                w_bad <= 1'b1;
                state <= IGNORE;
              end else if (instr_next[15]) begin
                shift_out <= rd_byte;
                state     <= RD_DATA;
              end else begin
                state <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (sclk_fall) begin
              sdo       <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
              sdo_oe    <= 1'b1;
            end
            if (sclk_rise && bit_cnt == 5'd23) state <= WAIT_CS;
          end
          WR_DATA: if (sclk_rise) begin
            data_sh <= wr_byte;
            if (bit_cnt == 5'd23) begin
              wr_pend <= 1'b1;
              if (wr_ok) mem[addr_q[ADDR_BITS-1:0]] <= wr_byte;
              state <= WAIT_CS;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
